// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op codes,
// FSM encodings and operand-class helpers.
package muldiv_pkg;

    localparam int DATA_WIDTH_GPR = 32;

    localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
    localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic src0_signed(input logic [2:0] op);
        return op inside {MULDIV_OP_MUL, MULDIV_OP_MULH, MULDIV_OP_MULHSU,
                          MULDIV_OP_DIV, MULDIV_OP_REM};
    endfunction

    function automatic logic src1_signed(input logic [2:0] op);
        return op inside {MULDIV_OP_MUL, MULDIV_OP_MULH, MULDIV_OP_DIV, MULDIV_OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Turns the unsigned magnitude results into the final signed RV32M result and
// selects the half/word the op asks for.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int XLEN = DATA_WIDTH_GPR
) (
    input  logic [2:0]        op,
    input  logic [2*XLEN-1:0] prod,
    input  logic [XLEN-1:0]   quo,
    input  logic [XLEN-1:0]   rem,
    input  logic              neg_res,
    input  logic              neg_rem,
    output logic [XLEN-1:0]   result
);

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    always_comb begin
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -quo  : quo;
        rem_fix  = neg_rem ? -rem  : rem;
        result   = '0;
        case (op)
            MULDIV_OP_MUL:    result = prod_fix[XLEN-1:0];
            MULDIV_OP_MULH,
            MULDIV_OP_MULHSU,
            MULDIV_OP_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
            MULDIV_OP_DIV,
            MULDIV_OP_DIVU:   result = quo_fix;
            MULDIV_OP_REM,
            MULDIV_OP_REMU:   result = rem_fix;
            default:          result = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on unsigned magnitudes, with sign correction and flush abort.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = DATA_WIDTH_GPR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_0,
    input  logic [XLEN-1:0] src_1,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            out_valid,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    md_state_t         state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2:0]        op_reg;
    logic [2*XLEN-1:0] prod_reg;
    logic [XLEN:0]     rem_reg;
    logic [XLEN-1:0]   quo_reg;
    logic [XLEN-1:0]   oper_reg;
    logic              neg_res_reg;
    logic              neg_rem_reg;
    logic [XLEN-1:0]   result_reg;
    logic              ready_reg;
    logic              busy_reg;
    logic              out_valid_reg;

    logic              neg_0, neg_1, is_div, special;
    logic [XLEN-1:0]   mag_0, mag_1, spec_quo;
    logic [XLEN:0]     spec_rem;
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_shift, div_trial;
    logic [XLEN-1:0]   fix_result;

    // Accept-time decode: magnitudes, signs and the RISC-V special divide cases.
    always_comb begin
        is_div   = op_is_div(op);
        neg_0    = src0_signed(op) & src_0[XLEN-1];
        neg_1    = src1_signed(op) & src_1[XLEN-1];
        mag_0    = neg_0 ? -src_0 : src_0;
        mag_1    = neg_1 ? -src_1 : src_1;
        special  = 1'b0;
        spec_quo = '0;
        spec_rem = '0;
        if (is_div && src_1 == '0) begin
            special  = 1'b1;
            spec_quo = '1;
            spec_rem = {1'b0, src_0};
        end else if (is_div && src1_signed(op)
                     && src_0 == {1'b1, {(XLEN-1){1'b0}}} && src_1 == '1) begin
            special  = 1'b1;
            spec_quo = src_0;
            spec_rem = '0;
        end
    end

    always_comb begin
        mul_sum   = {1'b0, prod_reg[2*XLEN-1:XLEN]} + {1'b0, (prod_reg[0] ? oper_reg : {XLEN{1'b0}})};
        div_shift = {rem_reg, quo_reg[XLEN-1]};
        div_trial = div_shift - {2'b00, oper_reg};
    end

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .op      (op_reg),
        .prod    (prod_reg),
        .quo     (quo_reg),
        .rem     (rem_reg[XLEN-1:0]),
        .neg_res (neg_res_reg),
        .neg_rem (neg_rem_reg),
        .result  (fix_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= MD_IDLE;
            cnt_reg       <= '0;
            op_reg        <= '0;
            prod_reg      <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            oper_reg      <= '0;
            neg_res_reg   <= 1'b0;
            neg_rem_reg   <= 1'b0;
            result_reg    <= '0;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                MD_IDLE: begin
                    if (start && !flush) begin
                        op_reg    <= op;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        if (special) begin
                            // Preloaded raw with signs cleared so the shared fixer passes it through.
                            quo_reg     <= spec_quo;
                            rem_reg     <= spec_rem;
                            neg_res_reg <= 1'b0;
                            neg_rem_reg <= 1'b0;
                            cnt_reg     <= '0;
                            state_reg   <= MD_FIX;
                        end else begin
                            neg_res_reg <= neg_0 ^ neg_1;
                            neg_rem_reg <= is_div & neg_0;
                            if (is_div) begin
                                quo_reg  <= mag_0;
                                rem_reg  <= '0;
                                oper_reg <= mag_1;
                            end else begin
                                prod_reg <= {{XLEN{1'b0}}, mag_1};
                                oper_reg <= mag_0;
                            end
                            cnt_reg   <= CNT_W'(XLEN);
                            state_reg <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    if (flush) begin
                        state_reg <= MD_IDLE;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        if (op_reg[2]) begin
                            if (!div_trial[XLEN+1]) begin
                                rem_reg <= div_trial[XLEN:0];
                                quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
                            end else begin
                                rem_reg <= div_shift[XLEN:0];
                                quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            prod_reg <= {mul_sum, prod_reg[XLEN-1:1]};
                        end
                        cnt_reg <= cnt_reg - 1'b1;
                        if (cnt_reg == CNT_W'(1)) begin
                            state_reg <= MD_FIX;
                        end
                    end
                end
                MD_FIX: begin
                    busy_reg <= 1'b0;
                    if (flush) begin
                        state_reg <= MD_IDLE;
                        ready_reg <= 1'b1;
                    end else begin
                        result_reg    <= fix_result;
                        out_valid_reg <= 1'b1;
                        state_reg     <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    state_reg <= MD_IDLE;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= MD_IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = ready_reg;
    assign busy      = busy_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, special cases,
// flush, reset, ignored starts and back-to-back issue.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] src_0;
    logic [XLEN-1:0] src_1;
    logic            flush;
    logic            ready;
    logic            busy;
    logic            out_valid;
    logic [XLEN-1:0] result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_0     (src_0),
        .src_1     (src_1),
        .flush     (flush),
        .ready     (ready),
        .busy      (busy),
        .out_valid (out_valid),
        .result    (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Steps from a negedge until out_valid is seen, bounded.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    // Issues at the current negedge (cycle 0) and reports latency to out_valid.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
        int c;
        start = 1'b1; op = o; src_0 = a; src_1 = b;
        step();
        start = 1'b0;
        wait_valid(c);
        $display("%s op=%0d a=%h b=%h result=%h lat=%0d", tag, o, a, b, result, c + 1);
        check({tag, "_res"}, result, exp_r);
        check({tag, "_lat"}, 32'(c + 1), 32'(exp_lat));
        step();
    endtask

    initial begin
        int c;
        int c2;
        logic saw;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_0 = '0; src_1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("reset ready=%b busy=%b out_valid=%b result=%h", ready, busy, out_valid, result);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'h0);

        run_op("mul",    3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run_op("mulh",   3'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 34);
        run_op("mulhu",  3'd3, 32'd7, 32'hFFFFFFFD, 32'h00000006, 34);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34);
        run_op("div",    3'd4, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, 34);
        run_op("rem",    3'd6, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFE, 34);
        run_op("divu",   3'd5, 32'h80000000, 32'd3, 32'h2AAAAAAA, 34);
        run_op("remu",   3'd7, 32'd100, 32'd7, 32'd2, 34);
        run_op("divu0",  3'd5, 32'h1234, 32'd0, 32'hFFFFFFFF, 2);
        run_op("remu0",  3'd7, 32'h1234, 32'd0, 32'h00001234, 2);

        // Flush at cycle 10 of a MUL.
        start = 1'b1; op = 3'd0; src_0 = 32'd11; src_1 = 32'd13;
        step();
        start = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        $display("flush ready=%b busy=%b", ready, busy);
        check("flush_ready", 32'(ready), 32'd1);
        check("flush_busy", 32'(busy), 32'd0);
        saw = 1'b0;
        repeat (40) begin
            step();
            saw |= out_valid;
        end
        check("flush_novalid", 32'(saw), 32'd0);
        check("flush_result", result, 32'h00001234);

        // Flush together with start in IDLE drops the request.
        start = 1'b1; flush = 1'b1; op = 3'd0; src_0 = 32'd2; src_1 = 32'd2;
        step();
        start = 1'b0; flush = 1'b0;
        $display("flush+start ready=%b busy=%b", ready, busy);
        check("flushstart_ready", 32'(ready), 32'd1);
        check("flushstart_busy", 32'(busy), 32'd0);

        run_op("mulhu_ff", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
        run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2);
        run_op("div0",     3'd4, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFFF, 2);

        // Start while busy, operands changed mid-CALC.
        start = 1'b1; op = 3'd0; src_0 = 32'd5; src_1 = 32'd6;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1; op = 3'd5; src_0 = 32'd100; src_1 = 32'd7;
        step();
        src_0 = 32'd555; src_1 = 32'd3;
        step();
        start = 1'b0; op = 3'd0;
        wait_valid(c);
        $display("busy_start result=%h lat=%0d", result, c + 7);
        check("busystart_res", result, 32'd30);
        check("busystart_lat", 32'(c + 7), 32'd34);
        step();
        check("busystart_idle", 32'(ready), 32'd1);
        step();
        check("busystart_noq", 32'(busy), 32'd0);

        // rst at cycle 5 of a MUL.
        start = 1'b1; op = 3'd0; src_0 = 32'd2; src_1 = 32'd3;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        $display("midrst ready=%b busy=%b out_valid=%b result=%h", ready, busy, out_valid, result);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'h0);
        rst = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            step();
            saw |= out_valid;
        end
        check("midrst_novalid", 32'(saw), 32'd0);

        // Back-to-back: second start held through DONE, accepted in the next IDLE cycle.
        start = 1'b1; op = 3'd0; src_0 = 32'd3; src_1 = 32'd4;
        step();
        start = 1'b0;
        wait_valid(c);
        $display("b2b first result=%h lat=%0d", result, c + 1);
        check("b2b1_res", result, 32'd12);
        check("b2b1_lat", 32'(c + 1), 32'd34);
        check("b2b_done_ready", 32'(ready), 32'd0);
        start = 1'b1; op = 3'd0; src_0 = 32'd9; src_1 = 32'd9;
        step();
        check("b2b_idle_ready", 32'(ready), 32'd1);
        step();
        start = 1'b0;
        wait_valid(c2);
        $display("b2b second result=%h gap=%0d", result, c2 + 2);
        check("b2b2_res", result, 32'd81);
        check("b2b_gap", 32'(c2 + 2), 32'd35);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
